// File: rtl/ram_dp_pkg.sv
// Shared types and constants for the dual-port RAM: controller states,
// legal read latencies and a byte parity helper.
package ram_dp_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int READ_LATENCY_MIN = 1;
    localparam int READ_LATENCY_MAX = 2;

    // Even-parity bit for one byte: byte plus bit always holds an even number of ones.
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/ram_dp_rd_pipe.sv
// Response pipeline for one RAM port: carries valid, error and read data
// LATENCY cycles from acceptance to the port outputs; data is zero when not valid.
module ram_dp_rd_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    input  logic                  in_err,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic                  out_err,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic [LATENCY-1:0]    valid_q;
    logic [LATENCY-1:0]    err_q;
    logic [DATA_WIDTH-1:0] data_q [LATENCY];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            err_q   <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            err_q[0]   <= in_err;
            data_q[0]  <= in_valid ? in_data : '0;
            for (int k = 1; k < LATENCY; k++) begin
                valid_q[k] <= valid_q[k-1];
                err_q[k]   <= err_q[k-1];
                data_q[k]  <= data_q[k-1];
            end
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_err   = err_q[LATENCY-1];
    assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/ram_dp.sv
// Dual-port RAM: instruction read port plus data read/write port, zeroed word-by-word
// after reset. Optional per-byte even parity is enabled with macro RAM_DP_PARITY_EN.
module ram_dp
    import ram_dp_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int DEPTH        = 1024,
    parameter int READ_LATENCY = 1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    i_req,
    input  logic [ADDR_WIDTH-1:0]   i_address,
    output logic                    i_ready,
    output logic                    i_rvalid,
    output logic [DATA_WIDTH-1:0]   i_read_data,
    output logic                    i_err,
    input  logic                    d_req,
    input  logic                    d_wEn,
    input  logic [DATA_WIDTH/8-1:0] d_byte_en,
    input  logic [ADDR_WIDTH-1:0]   d_address,
    input  logic [DATA_WIDTH-1:0]   d_write_data,
    output logic                    d_ready,
    output logic                    d_rvalid,
    output logic                    d_err,
    output logic [DATA_WIDTH-1:0]   d_read_data,
    output state_t                  state
);

    localparam int NB  = DATA_WIDTH / 8;
    localparam int CW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LAT = (READ_LATENCY >= READ_LATENCY_MAX) ? READ_LATENCY_MAX : READ_LATENCY_MIN;

    state_t          state_q;
    logic [CW-1:0]   init_cnt;
    logic            ready_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= INIT;
            init_cnt <= '0;
            ready_q  <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == CW'(DEPTH - 1)) begin
                        state_q  <= READY;
                        ready_q  <= 1'b1;
                        init_cnt <= '0;
                    end
                end
                READY:   ready_q <= 1'b1;
                default: state_q <= INIT;
            endcase
        end
    end

    assign i_ready = ready_q;
    assign d_ready = ready_q;
    assign state   = state_q;

    logic          i_acc, d_acc, d_wr;
    logic          i_oor, d_oor;
    logic [CW-1:0] i_idx, d_idx;

    assign i_acc = ready_q & i_req;
    assign d_acc = ready_q & d_req;
    assign i_oor = {1'b0, i_address} >= (ADDR_WIDTH + 1)'(DEPTH);
    assign d_oor = {1'b0, d_address} >= (ADDR_WIDTH + 1)'(DEPTH);
    assign i_idx = i_address[CW-1:0];
    assign d_idx = d_address[CW-1:0];
    assign d_wr  = d_acc & d_wEn & ~d_oor;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  i_par_err, d_par_err;

`ifdef RAM_DP_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];

    function automatic logic [NB-1:0] word_parity(input logic [DATA_WIDTH-1:0] w);
        logic [NB-1:0] p;
        for (int k = 0; k < NB; k++) begin
            p[k] = even_parity(w[8*k +: 8]);
        end
        return p;
    endfunction

    assign i_par_err = ~i_oor & |(word_parity(mem[i_idx]) ^ par_mem[i_idx]);
    assign d_par_err = ~d_oor & |(word_parity(mem[d_idx]) ^ par_mem[d_idx]);
`else
    assign i_par_err = 1'b0;
    assign d_par_err = 1'b0;
`endif

    // Storage has no reset; the INIT sweep is what clears it.
    always_ff @(posedge clock) begin
        if (state_q == INIT) begin
            mem[init_cnt] <= '0;
`ifdef RAM_DP_PARITY_EN
            par_mem[init_cnt] <= '0;
`endif
        end else if (d_wr) begin
            for (int k = 0; k < NB; k++) begin
                if (d_byte_en[k]) begin
                    mem[d_idx][8*k +: 8] <= d_write_data[8*k +: 8];
`ifdef RAM_DP_PARITY_EN
                    par_mem[d_idx][k] <= even_parity(d_write_data[8*k +: 8]);
`endif
                end
            end
        end
    end

    // Both ports sample the array before this edge's write lands (read-before-write).
    logic [DATA_WIDTH-1:0] i_word, d_word;
    assign i_word = i_oor ? '0 : mem[i_idx];
    assign d_word = d_oor ? '0 : mem[d_idx];

    ram_dp_rd_pipe #(.DATA_WIDTH(DATA_WIDTH), .LATENCY(LAT)) u_i_pipe (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (i_acc),
        .in_err    (i_acc & (i_oor | i_par_err)),
        .in_data   (i_word),
        .out_valid (i_rvalid),
        .out_err   (i_err),
        .out_data  (i_read_data)
    );

    ram_dp_rd_pipe #(.DATA_WIDTH(DATA_WIDTH), .LATENCY(LAT)) u_d_pipe (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (d_acc & ~d_wEn),
        .in_err    (d_acc & (d_oor | (~d_wEn & d_par_err))),
        .in_data   (d_word),
        .out_valid (d_rvalid),
        .out_err   (d_err),
        .out_data  (d_read_data)
    );

endmodule

// File: tb/tb_ram_dp.sv
// Bench for ram_dp: directed vectors on a READ_LATENCY=1 and a READ_LATENCY=2 instance,
// expectations queued per port and checked by negedge monitors.
module tb_ram_dp;

    localparam int DW    = 32;
    localparam int AW    = 16;
    localparam int DEPTH = 16;
    localparam int NB    = DW / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] cyc = '0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst_n, rst2_n;

    logic            i_req, i_ready, i_rvalid, i_err;
    logic [AW-1:0]   i_address;
    logic [DW-1:0]   i_read_data;
    logic            d_req, d_wen, d_ready, d_rvalid, d_err;
    logic [NB-1:0]   d_byte_en;
    logic [AW-1:0]   d_address;
    logic [DW-1:0]   d_write_data, d_read_data;
    ram_dp_pkg::state_t state;

    logic            i2_req, i2_ready, i2_rvalid, i2_err;
    logic [AW-1:0]   i2_address;
    logic [DW-1:0]   i2_read_data;
    logic            d2_req, d2_wen, d2_ready, d2_rvalid, d2_err;
    logic [NB-1:0]   d2_byte_en;
    logic [AW-1:0]   d2_address;
    logic [DW-1:0]   d2_write_data, d2_read_data;
    ram_dp_pkg::state_t state2;

    ram_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(1)) dut (
        .clock(clk), .reset_n(rst_n),
        .i_req(i_req), .i_address(i_address), .i_ready(i_ready), .i_rvalid(i_rvalid),
        .i_read_data(i_read_data), .i_err(i_err),
        .d_req(d_req), .d_wEn(d_wen), .d_byte_en(d_byte_en), .d_address(d_address),
        .d_write_data(d_write_data), .d_ready(d_ready), .d_rvalid(d_rvalid), .d_err(d_err),
        .d_read_data(d_read_data), .state(state)
    );

    ram_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(2)) dut2 (
        .clock(clk), .reset_n(rst2_n),
        .i_req(i2_req), .i_address(i2_address), .i_ready(i2_ready), .i_rvalid(i2_rvalid),
        .i_read_data(i2_read_data), .i_err(i2_err),
        .d_req(d2_req), .d_wEn(d2_wen), .d_byte_en(d2_byte_en), .d_address(d2_address),
        .d_write_data(d2_write_data), .d_ready(d2_ready), .d_rvalid(d2_rvalid), .d_err(d2_err),
        .d_read_data(d2_read_data), .state(state2)
    );

    // Expectation entry: {due_cycle[31:0], valid, err, data[31:0]}
    logic [65:0] i_exp_q[$];
    logic [65:0] d_exp_q[$];
    logic [65:0] i2_exp_q[$];

    int applied = 0;
    int miscompares = 0;

    function automatic logic [65:0] mk(input logic v, input logic e, input logic [31:0] d, input int lat);
        return {cyc + 32'(lat), v, e, d};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cmp_resp(input string name, input logic [65:0] e, input logic v, input logic er,
                            input logic [31:0] d);
        applied++;
        if (v !== e[33] || er !== e[32] || d !== e[31:0] || cyc !== e[65:34]) begin
            miscompares++;
            $display("FAIL %s: got valid=%0b err=%0b data=0x%08h cycle=%0d, expected valid=%0b err=%0b data=0x%08h cycle=%0d",
                     name, v, er, d, cyc, e[33], e[32], e[31:0], e[65:34]);
        end
    endtask

    task automatic unexpected(input string name, input logic v, input logic er, input logic [31:0] d);
        applied++;
        miscompares++;
        $display("FAIL %s: unexpected response valid=%0b err=%0b data=0x%08h at cycle %0d, expected none",
                 name, v, er, d, cyc);
    endtask

    task automatic missing(input string name, input logic [65:0] e);
        applied++;
        miscompares++;
        $display("FAIL %s: no response at cycle %0d, expected valid=%0b err=%0b data=0x%08h",
                 name, e[65:34], e[33], e[32], e[31:0]);
    endtask

    always @(negedge clk) begin
        if (i_rvalid || i_err) begin
            if (i_exp_q.size() == 0) unexpected("i_resp", i_rvalid, i_err, i_read_data);
            else cmp_resp("i_resp", i_exp_q.pop_front(), i_rvalid, i_err, i_read_data);
        end else begin
            if (i_read_data !== '0) check("i_idle_data", i_read_data, 32'h0);
            if (i_exp_q.size() != 0 && i_exp_q[0][65:34] <= cyc) missing("i_resp", i_exp_q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (d_rvalid || d_err) begin
            if (d_exp_q.size() == 0) unexpected("d_resp", d_rvalid, d_err, d_read_data);
            else cmp_resp("d_resp", d_exp_q.pop_front(), d_rvalid, d_err, d_read_data);
        end else begin
            if (d_read_data !== '0) check("d_idle_data", d_read_data, 32'h0);
            if (d_exp_q.size() != 0 && d_exp_q[0][65:34] <= cyc) missing("d_resp", d_exp_q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (i2_rvalid || i2_err) begin
            if (i2_exp_q.size() == 0) unexpected("i2_resp", i2_rvalid, i2_err, i2_read_data);
            else cmp_resp("i2_resp", i2_exp_q.pop_front(), i2_rvalid, i2_err, i2_read_data);
        end else begin
            if (i2_read_data !== '0) check("i2_idle_data", i2_read_data, 32'h0);
            if (i2_exp_q.size() != 0 && i2_exp_q[0][65:34] <= cyc) missing("i2_resp", i2_exp_q.pop_front());
        end
    end

    // Driver tasks are called just after a falling edge; step() moves to the next one.
    task automatic step();
        @(negedge clk);
        i_req = 1'b0; d_req = 1'b0; d_wen = 1'b0;
        i2_req = 1'b0; d2_req = 1'b0; d2_wen = 1'b0;
    endtask

    task automatic i_rd(input logic [AW-1:0] a, input logic [31:0] exp_d, input logic exp_e);
        i_req = 1'b1; i_address = a;
        i_exp_q.push_back(mk(1'b1, exp_e, exp_d, 1));
    endtask

    task automatic d_rd(input logic [AW-1:0] a, input logic [31:0] exp_d, input logic exp_e);
        d_req = 1'b1; d_wen = 1'b0; d_address = a;
        d_exp_q.push_back(mk(1'b1, exp_e, exp_d, 1));
    endtask

    task automatic d_wr(input logic [AW-1:0] a, input logic [31:0] data, input logic [NB-1:0] be,
                        input logic exp_e);
        d_req = 1'b1; d_wen = 1'b1; d_address = a; d_write_data = data; d_byte_en = be;
        if (exp_e) d_exp_q.push_back(mk(1'b0, 1'b1, 32'h0, 1));
    endtask

    task automatic i2_rd(input logic [AW-1:0] a, input logic [31:0] exp_d);
        i2_req = 1'b1; i2_address = a;
        i2_exp_q.push_back(mk(1'b1, 1'b0, exp_d, 2));
    endtask

    task automatic d2_wr(input logic [AW-1:0] a, input logic [31:0] data);
        d2_req = 1'b1; d2_wen = 1'b1; d2_address = a; d2_write_data = data; d2_byte_en = '1;
    endtask

    task automatic wait_ready(input bit sel, input string name);
        int low = 0;
        while (((sel ? i2_ready : i_ready) == 1'b0) && low < 100) begin
            low++;
            @(negedge clk);
        end
        check(name, 32'(low), 32'(DEPTH));
        check({name, "_d"}, 32'(sel ? d2_ready : d_ready), 32'h1);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; rst2_n = 1'b0;
        i_req = 1'b0; i_address = '0;
        d_req = 1'b0; d_wen = 1'b0; d_byte_en = '0; d_address = '0; d_write_data = '0;
        i2_req = 1'b0; i2_address = '0;
        d2_req = 1'b0; d2_wen = 1'b0; d2_byte_en = '0; d2_address = '0; d2_write_data = '0;

        repeat (3) @(negedge clk);
        check("rst_i_ready", 32'(i_ready), 32'h0);
        check("rst_d_ready", 32'(d_ready), 32'h0);
        check("rst_i_rvalid", 32'(i_rvalid), 32'h0);
        check("rst_d_rvalid", 32'(d_rvalid), 32'h0);
        check("rst_errs", {30'h0, i_err, d_err}, 32'h0);
        check("rst_state", 32'(state), 32'(ram_dp_pkg::INIT));

        // Requests held during INIT must be ignored: write and read to addr 5.
        rst_n = 1'b1; rst2_n = 1'b1;
        i_req = 1'b1; i_address = 16'd5;
        d_req = 1'b1; d_wen = 1'b1; d_address = 16'd5; d_write_data = 32'hFFFF_FFFF; d_byte_en = '1;
        wait_ready(1'b0, "ready_low_cycles");
        i_req = 1'b0; d_req = 1'b0; d_wen = 1'b0;
        check("ready2_after_init", 32'(i2_ready), 32'h1);
        check("state_ready", 32'(state), 32'(ram_dp_pkg::READY));

        i_rd(16'd5, 32'h0, 1'b0);                          step();
        d_wr(16'd4, 32'hDEAD_BEEF, 4'b1111, 1'b0);         step();
        d_wr(16'd4, 32'h0000_1200, 4'b0010, 1'b0);         step();
        i_rd(16'd4, 32'hDEAD_12EF, 1'b0);                  step();
        d_wr(16'd8, 32'h0000_0002, 4'b1111, 1'b0);
        i_rd(16'd8, 32'h0, 1'b0);                          step();
        i_rd(16'd8, 32'h0000_0002, 1'b0);                  step();
        i_rd(16'd20, 32'h0, 1'b1);
        d_rd(16'd20, 32'h0, 1'b1);                         step();
        d_wr(16'd20, 32'hFFFF_FFFF, 4'b1111, 1'b1);        step();
        d_rd(16'd4, 32'hDEAD_12EF, 1'b0);                  step();
        d_wr(16'd4, 32'hFFFF_FFFF, 4'b0000, 1'b0);         step();
        i_rd(16'd4, 32'hDEAD_12EF, 1'b0);
        d_rd(16'd8, 32'h0000_0002, 1'b0);                  step();
        i_rd(16'd8, 32'h0000_0002, 1'b0);                  step();
        i_rd(16'd15, 32'h0, 1'b0);                         step();
        d_wr(16'd15, 32'hA5A5_5A5A, 4'b1001, 1'b0);        step();
        d_rd(16'd15, 32'hA500_005A, 1'b0);
        i_rd(16'd15, 32'hA500_005A, 1'b0);                 step();
        i_rd(16'd16, 32'h0, 1'b1);                         step();

        // Latency-2 instance: back-to-back reads give responses on consecutive cycles.
        d2_wr(16'd1, 32'hA5A5_0001);                       step();
        d2_wr(16'd2, 32'h0000_0B02);                       step();
        i2_rd(16'd0, 32'h0);                               step();
        i2_rd(16'd1, 32'hA5A5_0001);                       step();
        i2_rd(16'd2, 32'h0000_0B02);                       step();
        repeat (3) step();

        // Reset mid-stream: in-flight reads are dropped and INIT restarts.
        i2_req = 1'b1; i2_address = 16'd1;                 step();
        i2_req = 1'b1; i2_address = 16'd2;
        rst2_n = 1'b0;
        #1;
        check("rst2_i_ready", 32'(i2_ready), 32'h0);
        check("rst2_state", 32'(state2), 32'(ram_dp_pkg::INIT));
        step();
        step();
        rst2_n = 1'b1;
        wait_ready(1'b1, "ready2_low_after_reset");
        i2_rd(16'd1, 32'h0);                               step();
        i2_rd(16'd2, 32'h0);                               step();

`ifdef RAM_DP_PARITY_EN
        d_wr(16'd3, 32'h1234_5678, 4'b1111, 1'b0);         step();
        step();
        dut.mem[3][0] = ~dut.mem[3][0];
        i_rd(16'd3, 32'h1234_5679, 1'b1);                  step();
        i_rd(16'd4, 32'hDEAD_12EF, 1'b0);                  step();
`endif

        repeat (4) step();
        check("i_queue_drained", 32'(i_exp_q.size()), 32'h0);
        check("d_queue_drained", 32'(d_exp_q.size()), 32'h0);
        check("i2_queue_drained", 32'(i2_exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/ram_dp.md
RAM_DP -- requirements
Module: ram_dp

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits; multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, word-address width.
REQ-003 SHALL have parameter DEPTH, default 1024, number of words; DEPTH <= 2**ADDR_WIDTH.
REQ-004 SHALL have parameter READ_LATENCY, default 1, legal values 1 or 2 cycles.
REQ-005 SHALL have one clock; reset is asynchronous and active-low: clock  in  1  rising-edge clock; reset_n  in  1  async active-low reset.
REQ-006 i_req  in  1  instruction read request; i_address  in  ADDR_WIDTH  instruction word address.
REQ-007 i_ready  out  1  port accepting; i_rvalid  out  1  read data valid; i_read_data  out  DATA_WIDTH; i_err  out  1  error with response.
REQ-008 d_req  in  1  data request; d_wEn  in  1  1=write, 0=read; d_byte_en  in  DATA_WIDTH/8  write byte strobes.
REQ-009 d_address  in  ADDR_WIDTH; d_write_data  in  DATA_WIDTH; d_ready, d_rvalid, d_err  out  1; d_read_data  out  DATA_WIDTH.

Function
REQ-010 SHALL implement state machine INIT -> READY; INIT entered on reset, READY entered the cycle after the init counter writes word DEPTH-1.
REQ-011 In INIT, SHALL zero one word per cycle, counter 0..DEPTH-1; i_ready=d_ready=0; requests ignored, no responses.
REQ-012 In READY, i_ready=d_ready=1 every cycle (no backpressure); request accepted when req=1 at a rising edge.
REQ-013 Accepted read SHALL return rvalid=1 for exactly one cycle, READ_LATENCY cycles after acceptance; back-to-back reads give one response per cycle, in order.
REQ-014 Accepted write SHALL update only bytes with d_byte_en[k]=1; d_byte_en=0 is a no-op; writes produce no d_rvalid.
REQ-015 read_data SHALL be 0 whenever rvalid=0.
REQ-016 Same-cycle data write and instruction read of the same address: instruction port SHALL return the pre-write value (read-before-write).
REQ-017 Address >= DEPTH: read returns 0 with rvalid=1 and err=1; write is discarded and d_err pulses once at the read-latency slot with d_rvalid=0.
REQ-018 err SHALL only assert coincident with a response slot; otherwise 0.

Reset
REQ-019 On reset_n=0: all rvalid/err/read_data outputs 0, i_ready=d_ready=0, state=INIT, counter=0, in-flight responses dropped.
REQ-020 Reset asserted mid-INIT or mid-READY SHALL restart INIT from word 0 after deassertion.

Configuration
REQ-021 Macro RAM_DP_PARITY_EN: when defined, SHALL store one even-parity bit per byte; on read, any mismatch sets err=1 with rvalid=1 and data still returned; INIT writes correct parity.
REQ-022 Without RAM_DP_PARITY_EN: no parity storage; err reflects only REQ-017.

Structure
REQ-023 Package ram_dp_pkg SHALL hold the state enum (INIT, READY) and legal READ_LATENCY constants.
REQ-024 Sub-module ram_dp_rd_pipe SHALL implement the per-port valid/data/err latency pipeline, instantiated once per port.

Verification (DATA_WIDTH=32, DEPTH=16, READ_LATENCY=1 unless stated)
REQ-025 Reset release -> ready low 16 cycles, then high; read addr 5 -> 0x00000000, err=0.
REQ-026 Write 0xDEADBEEF to addr 4, byte_en=4'b1111, then byte_en=4'b0010 data 0x00001200 -> read addr 4 returns 0xDEAD12EF.
REQ-027 Same cycle: d write 0x00000002 addr 8, i read addr 8 -> i_read_data 0x00000000; next i read addr 8 -> 0x00000002.
REQ-028 Read addr 20 -> rvalid=1, data 0, err=1; write addr 20 -> d_err pulse, memory unchanged.
REQ-029 READ_LATENCY=2, i reads addr 0,1,2 back-to-back -> three responses in consecutive cycles starting 2 cycles after first accept; reset_n pulsed mid-stream -> all responses dropped, INIT restarts.
REQ-030 RAM_DP_PARITY_EN defined, flip one stored data bit at addr 3 hierarchically -> read addr 3 gives err=1, rvalid=1.
